// File: rtl/video_ram_arbiter.sv
// video_ram_arbiter: single-port video RAM shared by display scanout (absolute priority) and a CPU.
// Define VRAM_ARB_BLANK_ONLY_EN to let the CPU in only during horizontal or vertical blank.
module video_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hblank,
  input  logic              i_vblank,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_rdata,
  output logic              o_disp_rvalid,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_rvalid,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [15:0]       o_conflicts
);
  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_ISSUE = 2'd1;
  localparam logic [1:0] C_DONE  = 2'd2;
  logic [1:0] state;
  logic gate, grant, blocked, vb_q, disp_p1;
`ifdef VRAM_ARB_BLANK_ONLY_EN
  assign gate = i_hblank | i_vblank;
`else
  logic unused_hblank;
  assign unused_hblank = i_hblank;
  assign gate = 1'b1;
`endif
  assign grant   = (state == C_IDLE) & i_cpu_req & ~i_disp_req & gate;
  assign blocked = (state == C_IDLE) & i_cpu_req & ~grant;
  // RAM returns data the cycle after the access, so read data is steered by the rvalid flags
  assign o_disp_rdata = o_disp_rvalid ? i_mem_rdata : '0;
  assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= C_IDLE;
      o_mem_en      <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_cpu_ack     <= 1'b0;
      o_cpu_rvalid  <= 1'b0;
      disp_p1       <= 1'b0;
      o_disp_rvalid <= 1'b0;
      vb_q          <= 1'b0;
      o_conflicts   <= '0;
    end else begin
      state         <= grant ? C_ISSUE : (state == C_ISSUE) ? C_DONE : C_IDLE;
      o_mem_en      <= i_disp_req | grant;
      o_mem_we      <= grant & i_cpu_we;
      o_mem_addr    <= i_disp_req ? i_disp_addr : grant ? i_cpu_addr : o_mem_addr;
      o_mem_wdata   <= grant ? i_cpu_wdata : o_mem_wdata;
      o_cpu_ack     <= grant;
      o_cpu_rvalid  <= (state == C_ISSUE) & ~o_mem_we;
      disp_p1       <= i_disp_req;
      o_disp_rvalid <= disp_p1;
      vb_q          <= i_vblank;
      o_conflicts   <= (i_vblank & ~vb_q) ? '0 : (blocked & ~&o_conflicts) ? o_conflicts + 16'd1 : o_conflicts;
    end
  end
endmodule
